// File: rtl/bsg_manycore_vcache_wh_mem_responder.sv
// Memory-side vcache DMA endpoint on a wormhole link.
// Serves block reads/writes from an internal flop memory.
module bsg_manycore_vcache_wh_mem_responder #(
  parameter int wh_flit_width_p = 32,
  parameter int wh_cord_width_p = 4,
  parameter int wh_len_width_p  = 4,
  parameter int wh_cid_width_p  = 4,
  parameter int block_flits_p   = 8,
  parameter int mem_els_p       = 64,
  parameter int my_cord_p       = 0
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [wh_flit_width_p+1:0] wh_link_sif_i,
  output logic [wh_flit_width_p+1:0] wh_link_sif_o
);

  localparam int fw_lp   = wh_flit_width_p;
  localparam int cw_lp   = wh_cord_width_p;
  localparam int lw_lp   = wh_len_width_p;
  localparam int iw_lp   = wh_cid_width_p;
  localparam int blk_w_lp  = $clog2(mem_els_p);
  localparam int off_lp    = $clog2(block_flits_p*fw_lp/8);
  localparam int beat_w_lp = $clog2(block_flits_p+1);
  localparam int bi_w_lp   = (block_flits_p > 1)
                           ? $clog2(block_flits_p) : 1;

  localparam int len_pos_lp  = cw_lp;
  localparam int dcid_pos_lp = cw_lp + lw_lp;
  localparam int scrd_pos_lp = cw_lp + lw_lp + iw_lp;
  localparam int scid_pos_lp = 2*cw_lp + lw_lp + iw_lp;
  localparam int wnr_pos_lp  = 2*cw_lp + lw_lp + 2*iw_lp;

  localparam logic [2:0] s_idle  = 3'd0;
  localparam logic [2:0] s_addr  = 3'd1;
  localparam logic [2:0] s_body  = 3'd2;
  localparam logic [2:0] s_rhdr  = 3'd3;
  localparam logic [2:0] s_rdata = 3'd4;

  localparam logic [beat_w_lp-1:0] beat_max_lp =
    beat_w_lp'(block_flits_p);
  localparam logic [beat_w_lp-1:0] beat_last_lp =
    beat_w_lp'(block_flits_p-1);
  localparam logic [lw_lp-1:0] one_len_lp = lw_lp'(1);

  logic              in_v;
  logic              out_credit;
  logic [fw_lp-1:0]  in_data;
  logic              in_rdy;
  logic              out_v;
  logic [fw_lp-1:0]  out_data;
  logic              in_hs;
  logic              out_hs;

  assign in_v       = wh_link_sif_i[fw_lp+1];
  assign out_credit = wh_link_sif_i[fw_lp];
  assign in_data    = wh_link_sif_i[fw_lp-1:0];
  assign wh_link_sif_o = {out_v, in_rdy, out_data};

  logic [2:0]           state_q, state_d;
  logic [lw_lp-1:0]     rem_q, rem_d;
  logic [beat_w_lp-1:0] beat_q, beat_d;
  logic [blk_w_lp-1:0]  blk_q, blk_d;
  logic [cw_lp-1:0]     src_cord_q, src_cord_d;
  logic [iw_lp-1:0]     src_cid_q, src_cid_d;
  logic                 wnr_q, wnr_d;
  logic                 live_q, live_d;
  logic                 mem_we;

  logic [fw_lp-1:0] mem_q [mem_els_p][block_flits_p];
  logic [fw_lp-1:0] rsp_hdr;
  logic [lw_lp-1:0] in_len;

  assign in_len = in_data[len_pos_lp +: lw_lp];

  // live_q holds ready low until the first edge after reset release
  assign in_rdy = live_q & ((state_q == s_idle)
                          | (state_q == s_addr)
                          | (state_q == s_body));
  assign out_v  = (state_q == s_rhdr) | (state_q == s_rdata);
  assign in_hs  = in_v & in_rdy;
  assign out_hs = out_v & out_credit;
  assign live_d = 1'b1;

  always_comb begin
    rsp_hdr = '0;
    rsp_hdr[0 +: cw_lp]           = src_cord_q;
    rsp_hdr[len_pos_lp +: lw_lp]  = lw_lp'(block_flits_p);
    rsp_hdr[dcid_pos_lp +: iw_lp] = src_cid_q;
    rsp_hdr[scrd_pos_lp +: cw_lp] = cw_lp'(my_cord_p);
  end

  assign out_data = (state_q == s_rhdr)
                  ? rsp_hdr
                  : mem_q[blk_q][beat_q[bi_w_lp-1:0]];

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    beat_d     = beat_q;
    blk_d      = blk_q;
    src_cord_d = src_cord_q;
    src_cid_d  = src_cid_q;
    wnr_d      = wnr_q;
    mem_we     = 1'b0;
    unique case (state_q)
      s_idle: begin
        if (in_hs) begin
          src_cord_d = in_data[scrd_pos_lp +: cw_lp];
          src_cid_d  = in_data[scid_pos_lp +: iw_lp];
          wnr_d      = in_data[wnr_pos_lp];
          rem_d      = in_len;
          beat_d     = '0;
          if (in_len != '0) state_d = s_addr;
        end
      end
      s_addr: begin
        if (in_hs) begin
          blk_d  = in_data[off_lp +: blk_w_lp];
          rem_d  = rem_q - one_len_lp;
          beat_d = '0;
          if (rem_q == one_len_lp)
            state_d = wnr_q ? s_idle : s_rhdr;
          else
            state_d = s_body;
        end
      end
      s_body: begin
        if (in_hs) begin
          rem_d  = rem_q - one_len_lp;
          mem_we = wnr_q & (beat_q < beat_max_lp);
          beat_d = (beat_q == beat_max_lp)
                 ? beat_q
                 : beat_q + beat_w_lp'(1);
          if (rem_q == one_len_lp) begin
            state_d = wnr_q ? s_idle : s_rhdr;
            beat_d  = '0;
          end
        end
      end
      s_rhdr: begin
        if (out_hs) state_d = s_rdata;
      end
      s_rdata: begin
        if (out_hs) begin
          if (beat_q == beat_last_lp) begin
            state_d = s_idle;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + beat_w_lp'(1);
          end
        end
      end
      default: state_d = s_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= s_idle;
      rem_q      <= '0;
      beat_q     <= '0;
      blk_q      <= '0;
      src_cord_q <= '0;
      src_cid_q  <= '0;
      wnr_q      <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      beat_q     <= beat_d;
      blk_q      <= blk_d;
      src_cord_q <= src_cord_d;
      src_cid_q  <= src_cid_d;
      wnr_q      <= wnr_d;
      live_q     <= live_d;
    end
  end

  // Storage keeps its contents across reset
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[blk_q][beat_q[bi_w_lp-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_bsg_manycore_vcache_wh_mem_responder.sv
// Directed and random bench for the vcache wormhole memory responder.
// Flit layout: cord 4, len 4, cid 4; 8 flits per block, 64 blocks.
module tb_bsg_manycore_vcache_wh_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        v_i;
  logic        rdy_i;
  logic [31:0] data_i;
  logic [33:0] sif_i;
  logic [33:0] sif_o;
  logic        v_o;
  logic        rdy_o;
  logic [31:0] data_o;

  assign sif_i  = {v_i, rdy_i, data_i};
  assign v_o    = sif_o[33];
  assign rdy_o  = sif_o[32];
  assign data_o = sif_o[31:0];

  bsg_manycore_vcache_wh_mem_responder #(
    .wh_flit_width_p(32),
    .wh_cord_width_p(4),
    .wh_len_width_p(4),
    .wh_cid_width_p(4),
    .block_flits_p(8),
    .mem_els_p(64),
    .my_cord_p(3)
  ) dut (
    .clk_i(clk),
    .reset_n_i(rst_n),
    .wh_link_sif_i(sif_i),
    .wh_link_sif_o(sif_o)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model [64][8];
  logic [31:0] txq [16];
  bit          send_to;
  bit          rsp_to;
  logic [31:0] rsp_hdr;
  logic [31:0] rsp_data [8];

  function automatic logic [31:0] mk_hdr(
    int dcord, int len, int dcid, int scord, int scid, int wnr);
    logic [31:0] h;
    h = '0;
    h[3:0]   = dcord[3:0];
    h[7:4]   = len[3:0];
    h[11:8]  = dcid[3:0];
    h[15:12] = scord[3:0];
    h[19:16] = scid[3:0];
    h[20]    = wnr[0];
    return h;
  endfunction

  task automatic model_write(input int blk, input int n);
    for (int k = 2; k < n; k++)
      if (k - 2 < 8) model[blk][k-2] = txq[k];
  endtask

  task automatic send_pkt(input int n, input int gmax);
    bit hs;
    int t;
    send_to = 0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gmax)) begin
        v_i = 1'b0;
        @(posedge clk); #1;
      end
      v_i = 1'b1;
      data_i = txq[i];
      t = 0;
      forever begin
        hs = rdy_o;
        @(posedge clk); #1;
        if (hs) break;
        t++;
        if (t > 200) begin
          send_to = 1;
          break;
        end
      end
      v_i = 1'b0;
      if (send_to) break;
    end
  endtask

  task automatic recv_resp(input int gmax);
    bit take;
    logic [31:0] d;
    int t;
    rsp_to = 0;
    for (int b = 0; b < 9; b++) begin
      t = 0;
      forever begin
        rdy_i = (gmax == 0) ? 1'b1
              : ($urandom_range(0, gmax) != 0);
        take = v_o & rdy_i;
        d = data_o;
        @(posedge clk); #1;
        if (take) break;
        t++;
        if (t > 200) begin
          rsp_to = 1;
          break;
        end
      end
      if (rsp_to) break;
      if (b == 0) rsp_hdr = d;
      else rsp_data[b-1] = d;
    end
    rdy_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    v_i = 1'b0;
    rdy_i = 1'b0;
    data_i = '0;
    #12;
    vectors++;
    if (v_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_v_o: got %b expected 0", v_o);
    end
    vectors++;
    if (rdy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_rdy_o: got %b expected 0", rdy_o);
    end
    #10;
    rst_n = 1'b1;
    #1;
    vectors++;
    if (rdy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_rdy_pre_edge: got %b expected 0", rdy_o);
    end
    @(posedge clk); #1;
    vectors++;
    if (rdy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_rdy_post_edge: got %b expected 1", rdy_o);
    end
  endtask

  task automatic test_fill;
    for (int b = 0; b < 64; b++) begin
      txq[0] = mk_hdr(0, 9, 0, 1, 1, 1);
      txq[1] = 32'(b) << 5;
      for (int j = 0; j < 8; j++)
        txq[2+j] = 32'hA000 | (32'(b) << 4) | 32'(j);
      send_pkt(10, 0);
      model_write(b, 10);
      vectors++;
      if (send_to !== 1'b0) begin
        miscompares++;
        $display("FAIL fill_send blk %0d: got timeout expected accept", b);
      end
    end
  endtask

  task automatic test_write_read;
    txq[0] = mk_hdr(0, 9, 0, 4, 1, 1);
    txq[1] = 32'h60;
    for (int j = 0; j < 8; j++) txq[2+j] = 32'h100 + 32'(j);
    send_pkt(10, 1);
    model_write(3, 10);
    vectors++;
    if (v_o !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_no_rsp: got v_o %b expected 0", v_o);
    end
    txq[0] = mk_hdr(0, 1, 0, 5, 2, 0);
    txq[1] = 32'h60;
    send_pkt(2, 0);
    vectors++;
    if (v_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_latency: got v_o %b expected 1", v_o);
    end
    recv_resp(0);
    vectors++;
    if (rsp_to !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_timeout: got timeout expected response");
    end
    vectors++;
    if (rsp_hdr !== 32'h3285) begin
      miscompares++;
      $display("FAIL rd_hdr: got %h expected %h", rsp_hdr, 32'h3285);
    end
    for (int j = 0; j < 8; j++) begin
      vectors++;
      if (rsp_data[j] !== 32'h100 + 32'(j)) begin
        miscompares++;
        $display("FAIL rd_beat%0d: got %h expected %h",
                 j, rsp_data[j], 32'h100 + 32'(j));
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp;
    txq[0] = mk_hdr(0, 1, 0, 5, 2, 0);
    txq[1] = 32'h60;
    send_pkt(2, 0);
    rdy_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      exp = (b == 0) ? 32'h3285 : 32'h100 + 32'(b - 1);
      vectors++;
      if (v_o !== 1'b1 || data_o !== exp) begin
        miscompares++;
        $display("FAIL bp_pre%0d: got v %b data %h expected v 1 data %h",
                 b, v_o, data_o, exp);
      end
      @(posedge clk); #1;
    end
    rdy_i = 1'b0;
    repeat (5) begin
      vectors++;
      if (v_o !== 1'b1 || data_o !== 32'h103 || rdy_o !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold: got v %b data %h rdy %b expected v 1 data 103 rdy 0",
                 v_o, data_o, rdy_o);
      end
      @(posedge clk); #1;
    end
    rdy_i = 1'b1;
    for (int b = 3; b < 8; b++) begin
      vectors++;
      if (v_o !== 1'b1 || data_o !== 32'h100 + 32'(b)) begin
        miscompares++;
        $display("FAIL bp_beat%0d: got v %b data %h expected v 1 data %h",
                 b, v_o, data_o, 32'h100 + 32'(b));
      end
      @(posedge clk); #1;
    end
    rdy_i = 1'b0;
    vectors++;
    if (v_o !== 1'b0 || rdy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_end: got v %b rdy %b expected v 0 rdy 1", v_o, rdy_o);
    end
  endtask

  task automatic test_overlong_wrap;
    txq[0] = mk_hdr(0, 12, 0, 2, 3, 1);
    txq[1] = 32'h800;
    for (int j = 0; j < 11; j++) txq[2+j] = 32'h200 + 32'(j);
    send_pkt(13, 1);
    model_write(0, 13);
    vectors++;
    if (send_to !== 1'b0) begin
      miscompares++;
      $display("FAIL long_accept: got timeout expected 13 flits accepted");
    end
    vectors++;
    if (v_o !== 1'b0) begin
      miscompares++;
      $display("FAIL long_no_rsp: got v_o %b expected 0", v_o);
    end
    txq[0] = mk_hdr(0, 1, 0, 2, 3, 0);
    txq[1] = 32'h0;
    send_pkt(2, 0);
    recv_resp(1);
    vectors++;
    if (rsp_to !== 1'b0 || rsp_hdr !== 32'h3382) begin
      miscompares++;
      $display("FAIL long_hdr: got to %b hdr %h expected to 0 hdr 3382",
               rsp_to, rsp_hdr);
    end
    for (int j = 0; j < 8; j++) begin
      vectors++;
      if (rsp_data[j] !== 32'h200 + 32'(j)) begin
        miscompares++;
        $display("FAIL long_beat%0d: got %h expected %h",
                 j, rsp_data[j], 32'h200 + 32'(j));
      end
    end
  endtask

  task automatic test_read_extra;
    txq[0] = mk_hdr(0, 3, 0, 7, 1, 0);
    txq[1] = 32'h60;
    txq[2] = 32'hDEAD0001;
    txq[3] = 32'hDEAD0002;
    send_pkt(4, 0);
    vectors++;
    if (send_to !== 1'b0 || v_o !== 1'b1) begin
      miscompares++;
      $display("FAIL extra_drain: got to %b v %b expected to 0 v 1",
               send_to, v_o);
    end
    recv_resp(0);
    vectors++;
    if (rsp_to !== 1'b0 || rsp_hdr !== 32'h3187) begin
      miscompares++;
      $display("FAIL extra_hdr: got to %b hdr %h expected to 0 hdr 3187",
               rsp_to, rsp_hdr);
    end
    for (int j = 0; j < 8; j++) begin
      vectors++;
      if (rsp_data[j] !== 32'h100 + 32'(j)) begin
        miscompares++;
        $display("FAIL extra_beat%0d: got %h expected %h",
                 j, rsp_data[j], 32'h100 + 32'(j));
      end
    end
    rdy_i = 1'b1;
    repeat (4) begin
      vectors++;
      if (v_o !== 1'b0) begin
        miscompares++;
        $display("FAIL extra_single: got v_o %b expected 0", v_o);
      end
      @(posedge clk); #1;
    end
    rdy_i = 1'b0;
  endtask

  task automatic test_reset_mid;
    txq[0] = mk_hdr(0, 9, 0, 1, 1, 1);
    txq[1] = 32'hA0;
    for (int j = 0; j < 4; j++) txq[2+j] = 32'h500 + 32'(j);
    send_pkt(6, 0);
    model_write(5, 6);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (v_o !== 1'b0 || rdy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_async: got v %b rdy %b expected v 0 rdy 0",
               v_o, rdy_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    txq[0] = mk_hdr(0, 1, 0, 6, 3, 0);
    txq[1] = 32'hA0;
    send_pkt(2, 0);
    recv_resp(0);
    vectors++;
    if (rsp_to !== 1'b0 || rsp_hdr !== 32'h3386) begin
      miscompares++;
      $display("FAIL mid_hdr: got to %b hdr %h expected to 0 hdr 3386",
               rsp_to, rsp_hdr);
    end
    for (int j = 0; j < 8; j++) begin
      vectors++;
      if (rsp_data[j] !== model[5][j]) begin
        miscompares++;
        $display("FAIL mid_beat%0d: got %h expected %h",
                 j, rsp_data[j], model[5][j]);
      end
    end
  endtask

  task automatic test_random;
    int scord, scid, blk, wr, len;
    logic [31:0] exp;
    for (int p = 0; p < 1000; p++) begin
      scord = $urandom_range(0, 15);
      scid  = $urandom_range(0, 15);
      blk   = $urandom_range(0, 63);
      wr    = $urandom_range(0, 1);
      if ($urandom_range(0, 19) == 0) len = 0;
      else if (wr != 0) len = $urandom_range(1, 15);
      else len = $urandom_range(1, 3);
      txq[0] = mk_hdr($urandom_range(0, 15), len,
                      $urandom_range(0, 15), scord, scid, wr);
      txq[1] = (32'(blk) << 5) | 32'($urandom_range(0, 31))
             | (32'($urandom_range(0, 7)) << 11);
      for (int k = 2; k <= len; k++) txq[k] = $urandom();
      send_pkt(len + 1, 2);
      vectors++;
      if (send_to !== 1'b0) begin
        miscompares++;
        $display("FAIL rand_send pkt %0d: got timeout expected accept", p);
      end
      if (len == 0 || wr != 0) begin
        if (len != 0) model_write(blk, len + 1);
        vectors++;
        if (v_o !== 1'b0) begin
          miscompares++;
          $display("FAIL rand_no_rsp pkt %0d: got v_o %b expected 0", p, v_o);
        end
      end else begin
        recv_resp(3);
        exp = mk_hdr(scord, 8, scid, 3, 0, 0);
        vectors++;
        if (rsp_to !== 1'b0 || rsp_hdr !== exp) begin
          miscompares++;
          $display("FAIL rand_hdr pkt %0d: got to %b hdr %h expected to 0 hdr %h",
                   p, rsp_to, rsp_hdr, exp);
        end
        for (int j = 0; j < 8; j++) begin
          vectors++;
          if (rsp_data[j] !== model[blk][j]) begin
            miscompares++;
            $display("FAIL rand_beat pkt %0d beat %0d: got %h expected %h",
                     p, j, rsp_data[j], model[blk][j]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_write_read;
    test_backpressure;
    test_overlong_wrap;
    test_read_extra;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
